bus_wr_target: RTL and testbench

BUS_WR_TARGET -- requirements
Module: bus_wr_target

---
 rtl/bus_wr_target_pkg.sv | 44 ++++
 rtl/bus_wr_target_if.sv | 24 ++
 rtl/bus_wr_target_wr_fifo.sv | 63 ++++++
 rtl/bus_wr_target.sv | 128 ++++++++++++
 tb/tb_bus_wr_target.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_wr_target_pkg.sv
// Shared definitions for the bus write target: address map, entry layout,
// commit FSM encoding and the address decode helper.
package bus_wr_target_pkg;

    localparam int ADDR_W     = 17;
    localparam int DATA_W     = 9;
    localparam int MEM_ADDR_W = 16;
    localparam int ENTRY_W    = 26;

    localparam logic [ADDR_W-1:0] MEM_LIMIT   = 17'h0FFFF;
    localparam logic [ADDR_W-1:0] LED_ADDR    = 17'h10000;
    localparam logic [ADDR_W-1:0] SCROLL_ADDR = 17'h10001;

    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        DEC_MEM,
        DEC_LED,
        DEC_SCROLL,
        DEC_DROP
    } dec_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    // Classify a buffered write by where its address lands in the map.
    function automatic dec_t decode(input logic [ADDR_W-1:0] addr);
        if (addr <= MEM_LIMIT) begin
            return DEC_MEM;
        end else if (addr == LED_ADDR) begin
            return DEC_LED;
        end else if (addr == SCROLL_ADDR) begin
            return DEC_SCROLL;
        end else begin
            return DEC_DROP;
        end
    endfunction

endpackage

// File: rtl/bus_wr_target_if.sv
// CPU store-path write bus: valid/ready handshake carrying address and data.
interface bus_wr_target_if;
    import bus_wr_target_pkg::*;

    logic [ADDR_W-1:0] bus_wraddr;
    logic [DATA_W-1:0] bus_wrdata;
    logic              bus_wrvalid;
    logic              bus_wrready;

    modport master (
        output bus_wraddr,
        output bus_wrdata,
        output bus_wrvalid,
        input  bus_wrready
    );

    modport slave (
        input  bus_wraddr,
        input  bus_wrdata,
        input  bus_wrvalid,
        output bus_wrready
    );

endinterface

// File: rtl/bus_wr_target_wr_fifo.sv
// wr_fifo: parameterised synchronous FIFO with registered occupancy count.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int             PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping; simultaneous push and pop leave the count unchanged.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage write port.
    // NOTE: storage is deliberately not reset; the cleared pointers and count make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/bus_wr_target.sv
// bus_wr_target: buffers CPU writes in a FIFO and commits them in order,
// either to memory (mem_* handshake) or to the LED / scroll control registers.
// Optional feature macro BUS_WR_DROPCNT_EN adds the saturating drop_cnt port
// counting writes to unmapped addresses.
module bus_wr_target
    import bus_wr_target_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    bus_wr_target_if.slave        bus,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_data,
    output logic                  mem_we,
    input  logic                  mem_ack,
    output logic [7:0]            led_reg,
    output logic [8:0]            scroll_reg
`ifdef BUS_WR_DROPCNT_EN
    ,
    output logic [7:0]            drop_cnt
`endif
);

    state_t    state_q;
    state_t    state_d;
    wr_entry_t push_entry;
    wr_entry_t head;
    dec_t      head_kind;
    logic      push;
    logic      pop;
    logic      full;
    logic      empty;

    // Ready depends only on the registered occupancy, never on bus_wrvalid.
    assign bus.bus_wrready = !full;
    assign push            = bus.bus_wrvalid && bus.bus_wrready;
    assign push_entry      = '{addr: bus.bus_wraddr, data: bus.bus_wrdata};
    assign head_kind       = decode(head.addr);

    wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (push_entry),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    // Commit FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and pop: pop only in IDLE; a memory entry parks the FSM until acknowledged.
    // NOTE: defaults come first so every path assigns every output and no latch is inferred.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (head_kind == DEC_MEM) begin
                        state_d = MEM_WAIT;
                    end
                end
            end
            MEM_WAIT: begin
                if (mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory request: load on a memory pop, hold stable until the acknowledging edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
        end else if (pop && head_kind == DEC_MEM) begin
            mem_we   <= 1'b1;
            mem_addr <= head.addr[MEM_ADDR_W-1:0];
            mem_data <= head.data;
        end else if (state_q == MEM_WAIT && mem_ack) begin
            mem_we   <= 1'b0;
        end
    end

    // Control registers update in the same cycle their entry is popped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_reg    <= '0;
            scroll_reg <= '0;
        end else if (pop) begin
            if (head_kind == DEC_LED) begin
                led_reg <= head.data[7:0];
            end
            if (head_kind == DEC_SCROLL) begin
                scroll_reg <= head.data;
            end
        end
    end

`ifdef BUS_WR_DROPCNT_EN
    // Saturating count of entries discarded for landing outside the address map.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (pop && head_kind == DEC_DROP && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bus_wr_target.sv
// Self-checking bench for bus_wr_target: directed scenarios plus a randomized
// phase, all scored against a transaction-level model of the address map.
module tb_bus_wr_target;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] mem_addr;
    logic [8:0]  mem_data;
    logic        mem_we;
    logic        mem_ack;
    logic [7:0]  led_reg;
    logic [8:0]  scroll_reg;
`ifdef BUS_WR_DROPCNT_EN
    logic [7:0]  drop_cnt;
`endif

    bus_wr_target_if bus ();

    bus_wr_target #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_we     (mem_we),
        .mem_ack    (mem_ack),
        .led_reg    (led_reg),
        .scroll_reg (scroll_reg)
`ifdef BUS_WR_DROPCNT_EN
        ,
        .drop_cnt   (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Model: every accepted write applied instantly in order. Memory writes
    // queue up with a snapshot of the control state they must commit behind.
    typedef struct {
        logic [15:0] addr;
        logic [8:0]  data;
        logic [7:0]  led;
        logic [8:0]  scroll;
        int          drops;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  m_led;
    logic [8:0]  m_scroll;
    int          m_drops;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          saw_we;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int sat8(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        m_led    = '0;
        m_scroll = '0;
        m_drops  = 0;
    endtask

    task automatic model_accept(input logic [16:0] addr, input logic [8:0] data);
        exp_t e;
        if (addr <= 17'h0FFFF) begin
            e.addr   = addr[15:0];
            e.data   = data;
            e.led    = m_led;
            e.scroll = m_scroll;
            e.drops  = m_drops;
            exp_q.push_back(e);
        end else if (addr == 17'h10000) begin
            m_led = data[7:0];
        end else if (addr == 17'h10001) begin
            m_scroll = data;
        end else begin
            m_drops++;
        end
    endtask

    // One clock cycle. Called at posedge+1 with inputs already driven.
    task automatic tick();
        bit take_ack;
        if (bus.bus_wrvalid && bus.bus_wrready) begin
            model_accept(bus.bus_wraddr, bus.bus_wrdata);
        end
        take_ack = mem_we && mem_ack;
        if (mem_we) begin
            saw_we = 1'b1;
            if (exp_q.size() == 0) begin
                check("we_unexpected", 32'(mem_we), 32'd0);
            end else begin
                check("mem_addr", 32'(mem_addr), 32'(exp_q[0].addr));
                check("mem_data", 32'(mem_data), 32'(exp_q[0].data));
            end
        end
        if (take_ack && exp_q.size() > 0) begin
            check("order_led", 32'(led_reg), 32'(exp_q[0].led));
            check("order_scroll", 32'(scroll_reg), 32'(exp_q[0].scroll));
`ifdef BUS_WR_DROPCNT_EN
            check("order_drop", 32'(drop_cnt), 32'(sat8(exp_q[0].drops)));
`endif
            void'(exp_q.pop_front());
        end
        @(posedge clk);
        #1;
        if (take_ack) begin
            check("we_gap", 32'(mem_we), 32'd0);
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        bus.bus_wrvalid = 1'b0;
        mem_ack         = 1'b1;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_done", 32'(exp_q.size()), 32'd0);
        repeat (DEPTH + 2) tick();
        mem_ack = 1'b0;
    endtask

    task automatic put(input logic [16:0] addr, input logic [8:0] data);
        bus.bus_wrvalid = 1'b1;
        bus.bus_wraddr  = addr;
        bus.bus_wrdata  = data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        int accepted;
        int guard;
        logic [16:0] a;

        bus.bus_wrvalid = 1'b0;
        bus.bus_wraddr  = '0;
        bus.bus_wrdata  = '0;
        mem_ack         = 1'b0;
        model_clear();
        saw_we = 1'b0;

        // Reset state, observed while reset is held.
        #1 rst = 1'b1;
        #1;
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_ready", 32'(bus.bus_wrready), 32'd1);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_data", 32'(mem_data), 32'd0);
        check("rst_led", 32'(led_reg), 32'd0);
        check("rst_scroll", 32'(scroll_reg), 32'd0);
`ifdef BUS_WR_DROPCNT_EN
        check("rst_drop", 32'(drop_cnt), 32'd0);
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Single memory write: four cycles of mem_we with ack low for three.
        put(17'h00123, 9'h1A5);
        check("lat_ready", 32'(bus.bus_wrready), 32'd1);
        tick();
        bus.bus_wrvalid = 1'b0;
        check("lat_edge_n", 32'(mem_we), 32'd0);
        tick();
        check("lat_edge_n1", 32'(mem_we), 32'd1);
        check("single_addr", 32'(mem_addr), 32'h0123);
        check("single_data", 32'(mem_data), 32'h1A5);
        repeat (3) begin
            check("single_hold", 32'(mem_we), 32'd1);
            tick();
        end
        check("single_cyc4", 32'(mem_we), 32'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("single_done", 32'(mem_we), 32'd0);
        repeat (2) tick();

        // Control writes never touch memory.
        saw_we = 1'b0;
        put(17'h10000, 9'h0F0);
        tick();
        put(17'h10001, 9'h155);
        tick();
        bus.bus_wrvalid = 1'b0;
        repeat (3) tick();
        check("ctrl_led", 32'(led_reg), 32'hF0);
        check("ctrl_scroll", 32'(scroll_reg), 32'h155);
        check("ctrl_no_we", 32'(saw_we), 32'd0);

        // Unmapped write: no side effect, drop count moves by one.
        put(17'h1FFFF, 9'h001);
        tick();
        bus.bus_wrvalid = 1'b0;
        repeat (3) tick();
        check("unmap_led", 32'(led_reg), 32'hF0);
        check("unmap_scroll", 32'(scroll_reg), 32'h155);
        check("unmap_no_we", 32'(saw_we), 32'd0);
`ifdef BUS_WR_DROPCNT_EN
        check("unmap_drop1", 32'(drop_cnt), 32'd1);
`endif

        // 300 more unmapped writes saturate the drop counter.
        accepted = 0;
        guard    = 0;
        while (accepted < 300 && guard < 2000) begin
            a = 17'h10002 + 17'($urandom_range(0, 32'h0FFFD));
            put(a, 9'($urandom));
            if (bus.bus_wrready) accepted++;
            tick();
            guard++;
        end
        check("unmap_all_accepted", 32'(accepted), 32'd300);
        drain(50);
        check("unmap_no_we_bulk", 32'(saw_we), 32'd0);
`ifdef BUS_WR_DROPCNT_EN
        check("drop_saturate", 32'(drop_cnt), 32'hFF);
`endif

        // Backpressure: five memory writes fill MEM_WAIT plus the whole FIFO.
        mem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            put(17'(i * 32'h1111 + 3), 9'($urandom));
            check("bp_ready_open", 32'(bus.bus_wrready), 32'd1);
            tick();
        end
        bus.bus_wrvalid = 1'b0;
        check("bp_ready_full", 32'(bus.bus_wrready), 32'd0);
        repeat (2) tick();
        check("bp_ready_held", 32'(bus.bus_wrready), 32'd0);
        check("bp_pending", 32'(exp_q.size()), 32'd5);
        drain(100);
        check("bp_ready_after", 32'(bus.bus_wrready), 32'd1);

        // Randomized traffic with random acknowledge, also outside MEM_WAIT.
        for (int c = 0; c < 600; c++) begin
            r = int'($urandom_range(0, 99));
            if (r < 50) begin
                a = {1'b0, 16'($urandom)};
            end else if (r < 65) begin
                a = 17'h10000;
            end else if (r < 80) begin
                a = 17'h10001;
            end else begin
                a = 17'h10002 + 17'($urandom_range(0, 32'h0FFFD));
            end
            put(a, 9'($urandom));
            bus.bus_wrvalid = ($urandom_range(0, 99) < 70);
            mem_ack         = ($urandom_range(0, 99) < 40);
            tick();
        end
        drain(400);
        check("rand_led", 32'(led_reg), 32'(m_led));
        check("rand_scroll", 32'(scroll_reg), 32'(m_scroll));
`ifdef BUS_WR_DROPCNT_EN
        check("rand_drop", 32'(drop_cnt), 32'(sat8(m_drops)));
`endif

        // Reset during MEM_WAIT with two entries still buffered.
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            put(17'(32'h0400 + i), 9'($urandom));
            tick();
        end
        bus.bus_wrvalid = 1'b0;
        check("mid_we", 32'(mem_we), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_we", 32'(mem_we), 32'd0);
        check("async_ready", 32'(bus.bus_wrready), 32'd1);
        check("async_addr", 32'(mem_addr), 32'd0);
        check("async_led", 32'(led_reg), 32'd0);
        model_clear();
        saw_we = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        mem_ack = 1'b1;
        repeat (8) tick();
        mem_ack = 1'b0;
        check("post_rst_no_commit", 32'(saw_we), 32'd0);
        check("post_rst_ready", 32'(bus.bus_wrready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
